// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with rename state (busy/tag) and a registered operand read port.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle clearing commit into the operand read.
module rename_regfile #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [AW-1:0]     issue_rs1,
    input  logic [AW-1:0]     issue_rs2,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_rd_we,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              rob_full,
    input  logic              commit_valid,
    input  logic [AW-1:0]     commit_rd,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              flush,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_v1,
    output logic [DATA_W-1:0] op_v2,
    output logic              op_busy1,
    output logic              op_busy2,
    output logic [TAG_W-1:0]  op_q1,
    output logic [TAG_W-1:0]  op_q2
);

    logic [DATA_W-1:0]   value_r [NUM_REGS];
    logic [TAG_W-1:0]    tag_r   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;

    logic                fire_s;
    logic                commit_wr_s;
    logic                commit_clr_s;
    logic [DATA_W-1:0]   src_v1_s;
    logic [DATA_W-1:0]   src_v2_s;
    logic                src_b1_s;
    logic                src_b2_s;
    logic [TAG_W-1:0]    src_q1_s;
    logic [TAG_W-1:0]    src_q2_s;

    // Handshake and commit qualifiers; a clearing commit must match the newest producer tag
    always_comb begin
        issue_ready  = !rob_full && !flush && !rst;
        fire_s       = issue_valid && issue_ready;
        commit_wr_s  = commit_valid && (commit_rd != {AW{1'b0}});
        commit_clr_s = commit_wr_s && busy_r[commit_rd] && (tag_r[commit_rd] == commit_tag);
    end

    // Source 1 lookup against pre-rename state
    always_comb begin
        if (issue_rs1 == {AW{1'b0}}) begin
            src_v1_s = {DATA_W{1'b0}};
            src_b1_s = 1'b0;
            src_q1_s = {TAG_W{1'b0}};
        end
`ifdef RF_COMMIT_BYPASS_EN
        else if (commit_clr_s && (issue_rs1 == commit_rd)) begin
            src_v1_s = commit_data;
            src_b1_s = 1'b0;
            src_q1_s = {TAG_W{1'b0}};
        end
`endif
        else begin
            src_v1_s = value_r[issue_rs1];
            src_b1_s = busy_r[issue_rs1];
            src_q1_s = busy_r[issue_rs1] ? tag_r[issue_rs1] : {TAG_W{1'b0}};
        end
    end

    // Source 2 lookup against pre-rename state
    always_comb begin
        if (issue_rs2 == {AW{1'b0}}) begin
            src_v2_s = {DATA_W{1'b0}};
            src_b2_s = 1'b0;
            src_q2_s = {TAG_W{1'b0}};
        end
`ifdef RF_COMMIT_BYPASS_EN
        else if (commit_clr_s && (issue_rs2 == commit_rd)) begin
            src_v2_s = commit_data;
            src_b2_s = 1'b0;
            src_q2_s = {TAG_W{1'b0}};
        end
`endif
        else begin
            src_v2_s = value_r[issue_rs2];
            src_b2_s = busy_r[issue_rs2];
            src_q2_s = busy_r[issue_rs2] ? tag_r[issue_rs2] : {TAG_W{1'b0}};
        end
    end

    // Register state; register 0 is never written so it stays at its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_r[i] <= {DATA_W{1'b0}};
                tag_r[i]   <= {TAG_W{1'b0}};
            end
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit_wr_s && (commit_rd == AW'(i))) begin
                    value_r[i] <= commit_data;
                end
                // Rename takes priority over a same-cycle clearing commit
                if (flush) begin
                    busy_r[i] <= 1'b0;
                    tag_r[i]  <= {TAG_W{1'b0}};
                end else if (fire_s && issue_rd_we && (issue_rd == AW'(i))) begin
                    busy_r[i] <= 1'b1;
                    tag_r[i]  <= issue_tag;
                end else if (commit_clr_s && (commit_rd == AW'(i))) begin
                    busy_r[i] <= 1'b0;
                end
            end
        end
    end

    // Registered operand outputs; they hold when nothing fires
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_v1    <= {DATA_W{1'b0}};
            op_v2    <= {DATA_W{1'b0}};
            op_busy1 <= 1'b0;
            op_busy2 <= 1'b0;
            op_q1    <= {TAG_W{1'b0}};
            op_q2    <= {TAG_W{1'b0}};
        end else begin
            op_valid <= fire_s;
            if (fire_s) begin
                op_v1    <= src_v1_s;
                op_v2    <= src_v2_s;
                op_busy1 <= src_b1_s;
                op_busy2 <= src_b2_s;
                op_q1    <= src_q1_s;
                op_q2    <= src_q2_s;
            end
        end
    end

endmodule
